comparador_serie_ctrl: RTL

COMPARADOR_SERIE_CTRL -- requirements
Module: comparador_serie_ctrl

---
 rtl/comparador_serie_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/comparador_serie_ctrl.sv
// Bit-serial unsigned magnitude comparator controller.
// Captures two N-bit operands on start and walks them from MSB to LSB through an
// external shared 1-bit equality comparator. It stops early on the first
// mismatching bit and reports eq/gt/lt with a one-cycle done pulse.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   start          begin a comparison (accepted only in IDLE)
//   a, b           N-bit operands, captured on accepted start
//   cmp_i0, cmp_i1 current bit of captured a / b to the comparator (combinational)
//   cmp_eq         comparator result, ~(cmp_i0 ^ cmp_i1)
//   busy           comparison in progress (RUN or DONE)
//   done           one-cycle result-valid pulse
//   eq, gt, lt     one-hot result flags, held until the next accepted start
module comparador_serie_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         cmp_i0,
    output logic         cmp_i1,
    input  logic         cmp_eq,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [N-1:0]    a_q, a_n;
    logic [N-1:0]    b_q, b_n;
    logic [IW-1:0]   idx_q, idx_n;
    logic            eq_n, gt_n, lt_n;
    logic            busy_n, done_n;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= IW'(N - 1);
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            b_q   <= b_n;
            idx_q <= idx_n;
            eq    <= eq_n;
            gt    <= gt_n;
            lt    <= lt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state, datapath update and comparator drive
    always_comb begin
        state_n = state;
        a_n     = a_q;
        b_n     = b_q;
        idx_n   = idx_q;
        eq_n    = eq;
        gt_n    = gt;
        lt_n    = lt;
        cmp_i0  = 1'b0;
        cmp_i1  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    idx_n   = IW'(N - 1);
                    eq_n    = 1'b0;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                cmp_i0 = a_q[idx_q];
                cmp_i1 = b_q[idx_q];
                if (!cmp_eq) begin
                    // First differing bit from the MSB decides the magnitude
                    gt_n    = a_q[idx_q];
                    lt_n    = b_q[idx_q];
                    eq_n    = 1'b0;
                    state_n = DONE;
                end else if (idx_q != '0) begin
                    idx_n = idx_q - IW'(1);
                end else begin
                    eq_n    = 1'b1;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // busy/done are registered copies of the upcoming state
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

endmodule
